// File: rtl/fir_column_linebuf.sv
// Vertical [1 4 6 4 1]/16 pass over 4 line buffers; 3-cycle latency, no backpressure (gaps propagate).
// Define FIR_COL_ROUND_EN for round-half-up output instead of truncation.
module fir_column_linebuf #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  valid_in,
    input  logic                  sof_in,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out,
    output logic                  sof_out,
    output logic                  eol_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int SW = DATA_WIDTH + 4;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb3_q [IMG_WIDTH];

    logic [DATA_WIDTH-1:0] t1, t2, t3, t4;
    logic [SW-1:0] so_d, si_d, sc_d, so_q, si_q, sc_q;
    logic [SW-1:0] total_d, total_q;
    logic [DATA_WIDTH-1:0] pix_d, pix_q;
    logic qual, sof_flag, eol_flag;
    logic [2:0] vld_q, sof_q, eol_q;

    // sof_in overrides the counters so the current pixel is always (0,0)
    always_comb begin
        cur_col = sof_in ? '0 : col_q;
        cur_row = sof_in ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (valid_in) begin
            if (cur_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Line buffers carry no reset; rows 0..3 of each frame overwrite stale content before use.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb0_q[cur_col] <= pixel_in;
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb2_q[cur_col] <= lb1_q[cur_col];
            lb3_q[cur_col] <= lb2_q[cur_col];
        end
    end

    always_comb begin
        t1       = lb0_q[cur_col];
        t2       = lb1_q[cur_col];
        t3       = lb2_q[cur_col];
        t4       = lb3_q[cur_col];
        so_d     = SW'(pixel_in) + SW'(t4);
        si_d     = (SW'(t1) + SW'(t3)) << 2;
        sc_d     = (SW'(t2) << 2) + (SW'(t2) << 1);
        total_d  = so_q + si_q + sc_q;
`ifdef FIR_COL_ROUND_EN
        pix_d    = DATA_WIDTH'(({1'b0, total_q} + (SW + 1)'(8)) >> 4);
`else
        pix_d    = DATA_WIDTH'(total_q >> 4);
`endif
        qual     = valid_in && (cur_row >= RW'(4));
        sof_flag = qual && (cur_row == RW'(4)) && (cur_col == '0);
        eol_flag = qual && (cur_col == CW'(IMG_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            so_q    <= '0;
            si_q    <= '0;
            sc_q    <= '0;
            total_q <= '0;
            pix_q   <= '0;
            vld_q   <= '0;
            sof_q   <= '0;
            eol_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            so_q    <= so_d;
            si_q    <= si_d;
            sc_q    <= sc_d;
            total_q <= total_d;
            pix_q   <= pix_d;
            vld_q   <= {vld_q[1:0], qual};
            sof_q   <= {sof_q[1:0], sof_flag};
            eol_q   <= {eol_q[1:0], eol_flag};
        end
    end

    assign pixel_out = pix_q;
    assign valid_out = vld_q[2];
    assign sof_out   = sof_q[2];
    assign eol_out   = eol_q[2];
endmodule

// File: tb/tb_fir_column_linebuf.sv
// Scoreboard bench for fir_column_linebuf at 8x10; expectations pushed at issue, checked by a monitor.
module tb_fir_column_linebuf;
    localparam int W = 8;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pixel_in;
    logic       valid_in;
    logic       sof_in;
    logic [7:0] pixel_out;
    logic       valid_out;
    logic       sof_out;
    logic       eol_out;

    fir_column_linebuf #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .pixel_in (pixel_in),
        .valid_in (valid_in),
        .sof_in   (sof_in),
        .pixel_out(pixel_out),
        .valid_out(valid_out),
        .sof_out  (sof_out),
        .eol_out  (eol_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tr = 0;
    int   tc = 0;

`ifdef FIR_COL_ROUND_EN
    logic [7:0] imp_tab [0:5] = '{8'd16, 8'd64, 8'd96, 8'd64, 8'd16, 8'd0};
`else
    logic [7:0] imp_tab [0:5] = '{8'd15, 8'd63, 8'd95, 8'd63, 8'd15, 8'd0};
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid_out must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (valid_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got pix=%0d sof=%0b eol=%0b at cyc %0d, required no output",
                         pixel_out, sof_out, eol_out, cyc);
            end else begin
                e = q.pop_front();
                if (pixel_out !== e.pix || sof_out !== e.sof || eol_out !== e.eol || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL output: got pix=%0d sof=%0b eol=%0b cyc=%0d, required pix=%0d sof=%0b eol=%0b cyc=%0d",
                             pixel_out, sof_out, eol_out, cyc, e.pix, e.sof, e.eol, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] pix, input logic sof, input logic [7:0] expv);
        exp_t x;
        pixel_in = pix;
        valid_in = 1'b1;
        sof_in   = sof;
        if (sof) begin
            tr = 0;
            tc = 0;
        end
        if (tr >= 4) begin
            x.pix = expv;
            x.sof = (tr == 4 && tc == 0);
            x.eol = (tc == W - 1);
            x.cyc = cyc + 3;
            q.push_back(x);
        end
        if (tc == W - 1) begin
            tc = 0;
            tr = (tr == H - 1) ? 0 : tr + 1;
        end else begin
            tc++;
        end
        step();
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    // kind 0: constant val; kind 1: 255 impulse at (4,3)
    task automatic send_frame(input int kind, input int gap, input logic [7:0] val, input logic first_sof);
        logic [7:0] p, x;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (kind == 1) begin
                    p = (r == 4 && c == 3) ? 8'd255 : 8'd0;
                    x = (c == 3 && r >= 4) ? imp_tab[r - 4] : 8'd0;
                end else begin
                    p = val;
                    x = val;
                end
                send_pixel(p, first_sof && r == 0 && c == 0, x);
                repeat (gap) step();
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (pixel_out !== 8'd0 || valid_out !== 1'b0 || sof_out !== 1'b0 || eol_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: got pix=%0d vld=%0b sof=%0b eol=%0b, required all 0",
                     name, pixel_out, valid_out, sof_out, eol_out);
        end
    endtask

    task automatic do_reset(input string name);
        int r_edge;
        reset    = 1'b1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        r_edge   = cyc + 1;
        while (q.size() > 0 && q[$].cyc >= r_edge) q.pop_back();
        step();
        check_zero(name);
        reset = 1'b0;
        tr = 0;
        tc = 0;
    endtask

    initial begin
        reset    = 1'b1;
        pixel_in = '0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        repeat (3) step();
        check_zero("reset_state");
        reset = 1'b0;
        step();

        // 1: constant 100, continuous
        send_frame(0, 0, 8'd100, 1'b1);
        // 2: impulse
        send_frame(1, 0, 8'd0, 1'b1);
        // 3: alternate-cycle valid
        send_frame(0, 1, 8'd100, 1'b1);
        // 4: sof mid-frame at (6,5), new frame of 80
        for (int i = 0; i < 6 * W + 5; i++) send_pixel(8'd100, i == 0, 8'd100);
        send_frame(0, 0, 8'd80, 1'b1);
        repeat (2) step();
        // 5: reset at (5,2) with the pipe full, then a fresh frame without sof
        for (int i = 0; i < 5 * W + 2; i++) send_pixel(8'd70, i == 0, 8'd70);
        do_reset("reset_midframe");
        send_frame(0, 0, 8'd50, 1'b0);
        // 6: full-scale
        send_frame(0, 0, 8'd255, 1'b1);

        repeat (8) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expectations, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
